// File: rtl/sha_mem_responder.sv
// Word-addressed memory for the SHA-256 engine, with a handshaked host port
// that is locked out while the engine runs. Also tracks out-of-range errors and engine writes.
module sha_mem_responder #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        mem_we_i,
   input  logic [15:0] mem_addr_i,
   input  logic [31:0] mem_write_data_i,
   output logic [31:0] mem_read_data_o,
   input  logic        engine_busy_i,
   input  logic        host_req_i,
   input  logic        host_we_i,
   input  logic [15:0] host_addr_i,
   input  logic [31:0] host_wdata_i,
   output logic        host_gnt_o,
   output logic        host_rvalid_o,
   output logic [31:0] host_rdata_o,
   input  logic        clear_i,
   output logic        err_oob_o,
   output logic [7:0]  wr_count_o
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {H_IDLE, H_ACK} hstate_e;

   logic [31:0] mem [DEPTH];

   hstate_e     state_q, state_d;
   logic [31:0] mem_read_data_q, host_rdata_q;
   logic        host_gnt_q, host_rvalid_q, err_oob_q;
   logic [7:0]  wr_count_q;

   logic          eng_ok, host_ok, host_go;
   logic [AW-1:0] eng_idx, host_idx, wr_idx;
   logic          wr_en;
   logic [31:0]   wr_data;

   assign eng_ok   = {16'b0, mem_addr_i}  < DEPTH;
   assign host_ok  = {16'b0, host_addr_i} < DEPTH;
   assign eng_idx  = mem_addr_i[AW-1:0];
   assign host_idx = host_addr_i[AW-1:0];

   // A host access happens only in an idle slot: engine not running and not writing.
   always_comb begin
      state_d = state_q;
      host_go = 1'b0;
      case (state_q)
         H_IDLE: begin
            if (host_req_i && !engine_busy_i && !mem_we_i && !reset_i) begin
               host_go = 1'b1;
               state_d = H_ACK;
            end
         end
         H_ACK: begin
            if (!host_req_i) state_d = H_IDLE;
         end
         default: state_d = H_IDLE;
      endcase
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = eng_idx;
      wr_data = mem_write_data_i;
      if (mem_we_i && eng_ok) begin
         wr_en = 1'b1;
      end else if (host_go && host_we_i && host_ok) begin
         wr_en   = 1'b1;
         wr_idx  = host_idx;
         wr_data = host_wdata_i;
      end
   end

   // Storage is never reset so completed writes survive a mid-handshake reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= H_IDLE;
         mem_read_data_q <= '0;
         host_rdata_q    <= '0;
         host_gnt_q      <= 1'b0;
         host_rvalid_q   <= 1'b0;
         err_oob_q       <= 1'b0;
         wr_count_q      <= '0;
      end else begin
         state_q         <= state_d;
         mem_read_data_q <= eng_ok ? mem[eng_idx] : '0;
         host_gnt_q      <= host_go;
         host_rvalid_q   <= host_go && !host_we_i;
         if (host_go && !host_we_i) host_rdata_q <= host_ok ? mem[host_idx] : '0;
         // clear wins over any event in the same cycle
         if (clear_i) begin
            err_oob_q  <= 1'b0;
            wr_count_q <= '0;
         end else begin
            if (!eng_ok || (host_go && !host_ok)) err_oob_q <= 1'b1;
            if (mem_we_i && eng_ok && wr_count_q != 8'hFF) wr_count_q <= wr_count_q + 8'd1;
         end
      end
   end

   assign mem_read_data_o = mem_read_data_q;
   assign host_rdata_o    = host_rdata_q;
   assign host_gnt_o      = host_gnt_q;
   assign host_rvalid_o   = host_rvalid_q;
   assign err_oob_o       = err_oob_q;
   assign wr_count_o      = wr_count_q;
endmodule

// File: tb/tb_sha_mem_responder.sv
// Scoreboard bench for sha_mem_responder: stimulus queues expected responses,
// a negedge monitor pops and compares them as the DUT presents data.
module tb_sha_mem_responder;
   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset, mem_we, engine_busy, host_req, host_we, clear;
   logic [15:0] mem_addr, host_addr;
   logic [31:0] mem_write_data, host_wdata;
   logic [31:0] mem_read_data, host_rdata;
   logic        host_gnt, host_rvalid, err_oob;
   logic [7:0]  wr_count;

   sha_mem_responder #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .reset_i(reset),
      .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_write_data_i(mem_write_data),
      .mem_read_data_o(mem_read_data), .engine_busy_i(engine_busy),
      .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
      .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
      .host_rdata_o(host_rdata), .clear_i(clear), .err_oob_o(err_oob), .wr_count_o(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {logic we; logic [31:0] d;} hexp_t;
   typedef struct {int cyc; logic [31:0] d;} eexp_t;
   hexp_t hq[$];
   eexp_t eq[$];
   int cyc = 0;
   int n_cmp = 0, n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: host responses on gnt, engine read data on the scheduled cycle.
   always @(negedge clk) begin
      if (host_gnt) begin
         if (hq.size() == 0) begin
            chk("host_unexpected_gnt", 32'd1, 32'd0);
         end else begin
            hexp_t h;
            h = hq.pop_front();
            chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, !h.we});
            if (!h.we) chk("host_rdata", host_rdata, h.d);
         end
      end
      if (eq.size() > 0 && eq[0].cyc <= cyc) begin
         eexp_t e;
         e = eq.pop_front();
         chk("eng_rdata", (e.cyc == cyc) ? mem_read_data : 32'hBAD0BAD0, e.d);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic host_acc(input logic we, input logic [15:0] a, input logic [31:0] d);
      int lat;
      hexp_t h;
      h.we = we; h.d = d;
      hq.push_back(h);
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!host_gnt && lat < 20);
      chk("host_latency", 32'(lat), 32'd1);
      host_req = 1'b0;
      tick();
   endtask

   task automatic eng_rd(input logic [15:0] a, input logic we, input logic [31:0] wd,
                         input logic [31:0] exp);
      eexp_t e;
      mem_addr = a; mem_we = we; mem_write_data = wd;
      e.cyc = cyc + 1; e.d = exp;
      eq.push_back(e);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; mem_we = 1'b0; engine_busy = 1'b0; host_req = 1'b0; host_we = 1'b0;
      clear = 1'b0; mem_addr = '0; host_addr = '0; mem_write_data = '0; host_wdata = '0;
      tick(); tick();
      chk("rst_mem_read_data", mem_read_data, 32'd0);
      chk("rst_host_rdata", host_rdata, 32'd0);
      chk("rst_gnt_rvalid", {30'b0, host_gnt, host_rvalid}, 32'd0);
      chk("rst_err_oob", {31'b0, err_oob}, 32'd0);
      chk("rst_wr_count", {24'b0, wr_count}, 32'd0);
      reset = 1'b0;
      tick();

      // host load and read-back
      for (int k = 0; k < 20; k++) host_acc(1'b1, 16'(k), 32'hA500_0000 + 32'(k));
      host_acc(1'b0, 16'd7, 32'hA500_0007);

      // engine read latency, out-of-range read, read-first
      host_acc(1'b1, 16'd3, 32'h1234_5678);
      eng_rd(16'd3, 1'b0, 32'd0, 32'h1234_5678);
      eng_rd(16'(DEPTH), 1'b0, 32'd0, 32'd0);
      eng_rd(16'd3, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      eng_rd(16'd3, 1'b0, 32'd0, 32'hDEAD_BEEF);
      eng_rd(16'd0, 1'b0, 32'd0, 32'hA500_0000);
      tick();
      chk("oob_read_err", {31'b0, err_oob}, 32'd1);
      chk("rf_wr_count", {24'b0, wr_count}, 32'd1);
      clear = 1'b1; tick(); clear = 1'b0; tick();
      chk("clear_err", {31'b0, err_oob}, 32'd0);
      chk("clear_cnt", {24'b0, wr_count}, 32'd0);

      // hash write while busy
      engine_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mem_we = 1'b1; mem_addr = 16'(100 + i); mem_write_data = 32'hC0DE_0000 + 32'(i);
         tick();
      end
      mem_we = 1'b0; mem_addr = '0;
      tick();
      chk("hash_wr_count", {24'b0, wr_count}, 32'd8);
      chk("hash_err", {31'b0, err_oob}, 32'd0);
      engine_busy = 1'b0;
      for (int i = 0; i < 8; i++) host_acc(1'b0, 16'(100 + i), 32'hC0DE_0000 + 32'(i));

      // arbitration: busy blocks, then a same-cycle engine write delays one more cycle
      begin
         hexp_t h;
         h.we = 1'b0; h.d = 32'hA500_0005;
         hq.push_back(h);
      end
      engine_busy = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 16'd5;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("arb_busy_no_gnt", {31'b0, host_gnt}, 32'd0);
      end
      engine_busy = 1'b0; mem_we = 1'b1; mem_addr = 16'd200; mem_write_data = 32'h0000_0200;
      tick();
      chk("arb_we_no_gnt", {31'b0, host_gnt}, 32'd0);
      mem_we = 1'b0; mem_addr = '0;
      tick();
      chk("arb_gnt", {31'b0, host_gnt}, 32'd1);
      host_req = 1'b0;
      tick();
      chk("arb_wr_count", {24'b0, wr_count}, 32'd9);

      // out-of-range write must not alias onto a low address
      mem_we = 1'b1; mem_addr = 16'(DEPTH + 5); mem_write_data = 32'hFFFF_FFFF;
      tick();
      mem_we = 1'b0; mem_addr = '0;
      tick();
      chk("oob_wr_err", {31'b0, err_oob}, 32'd1);
      chk("oob_wr_count", {24'b0, wr_count}, 32'd9);
      host_acc(1'b0, 16'd5, 32'hA500_0005);
      clear = 1'b1; mem_we = 1'b1; mem_addr = 16'd201; mem_write_data = 32'h0000_0201;
      tick();
      clear = 1'b0; mem_we = 1'b0; mem_addr = '0;
      tick();
      chk("clear_vs_wr_cnt", {24'b0, wr_count}, 32'd0);
      chk("clear_vs_wr_err", {31'b0, err_oob}, 32'd0);
      host_acc(1'b0, 16'd201, 32'h0000_0201);

      // saturation
      mem_we = 1'b1; mem_addr = 16'd300; mem_write_data = 32'h3;
      for (int i = 0; i < 260; i++) tick();
      mem_we = 1'b0; mem_addr = '0;
      tick();
      chk("sat_wr_count", {24'b0, wr_count}, 32'd255);

      // reset in H_ACK
      host_acc(1'b1, 16'd50, 32'h5A5A_5A5A);
      begin
         hexp_t h;
         h.we = 1'b0; h.d = 32'h5A5A_5A5A;
         hq.push_back(h);
      end
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'd50;
      tick();
      chk("ack_gnt", {31'b0, host_gnt}, 32'd1);
      reset = 1'b1; host_req = 1'b0;
      tick();
      chk("ackrst_mem_read_data", mem_read_data, 32'd0);
      chk("ackrst_host_rdata", host_rdata, 32'd0);
      chk("ackrst_gnt_rvalid", {30'b0, host_gnt, host_rvalid}, 32'd0);
      chk("ackrst_err_cnt", {23'b0, err_oob, wr_count}, 32'd0);
      reset = 1'b0;
      tick();
      host_acc(1'b0, 16'd50, 32'h5A5A_5A5A);

      tick(); tick();
      chk("host_queue_drained", 32'(hq.size()), 32'd0);
      chk("eng_queue_drained", 32'(eq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
